// File: rtl/mem_responder.sv
// Single-ported word memory shared by a fetch port and a data port, one access per 3 cycles.
// Optional define MEM_MISALIGN_ERR_EN: misaligned half/word data accesses are suppressed and flagged on d_err.
module mem_responder #(
  parameter int DEPTH_WORDS = 1024
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  output logic        if_ready,
  output logic        if_rvalid,
  output logic [31:0] if_rdata,
  input  logic        d_req,
  input  logic        d_we,
  input  logic [31:0] d_addr,
  input  logic [2:0]  d_func3,
  input  logic [31:0] d_wdata,
  output logic        d_ready,
  output logic        d_rvalid,
  output logic [31:0] d_rdata,
  output logic        d_err
);
  localparam int AW = $clog2(DEPTH_WORDS);

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

  state_t        state_q, state_d;
  logic          gnt_d_q, gnt_d_d;    // current transaction belongs to the data port
  logic          last_d_q, last_d_d;  // previous grant went to the data port
  logic          we_q, we_d;
  logic [2:0]    f3_q, f3_d;
  logic [AW+1:0] addr_q, addr_d;
  logic [31:0]   wdata_q, wdata_d;
  logic [31:0]   rdata_q, rdata_d;
  logic          err_q, err_d;

  logic [31:0]   mem [DEPTH_WORDS];

  logic          idle, acc_d, acc_if, resp;
  logic [AW-1:0] idx;
  logic [1:0]    boff;
  logic [31:0]   word, shifted, ld_val, wlane;
  logic [7:0]    byte_v;
  logic [15:0]   half_v;
  logic [3:0]    be;
  logic          misalign, mem_we;

  // Ready is a grant: only one port can see ready while both request.
  assign idle     = (state_q == IDLE) && !rst;
  assign d_ready  = idle && (!if_req || !last_d_q);
  assign if_ready = idle && (!d_req || last_d_q);
  assign acc_d    = d_req && d_ready;
  assign acc_if   = if_req && if_ready;

  assign idx     = addr_q[AW+1:2];
  assign boff    = addr_q[1:0];
  assign word    = mem[idx];
  assign shifted = word >> {boff, 3'b000};
  assign byte_v  = shifted[7:0];
  assign half_v  = boff[1] ? word[31:16] : word[15:0];

  always_comb begin
    ld_val = word;
    wlane  = wdata_q;
    be     = 4'b1111;
    case (f3_q[1:0])
      2'b00: begin
        ld_val = f3_q[2] ? {24'd0, byte_v} : {{24{byte_v[7]}}, byte_v};
        wlane  = {4{wdata_q[7:0]}};
        be     = 4'b0001 << boff;
      end
      2'b01: begin
        ld_val = f3_q[2] ? {16'd0, half_v} : {{16{half_v[15]}}, half_v};
        wlane  = {2{wdata_q[15:0]}};
        be     = boff[1] ? 4'b1100 : 4'b0011;
      end
      default: ;
    endcase
  end

`ifdef MEM_MISALIGN_ERR_EN
  assign misalign = gnt_d_q && (((f3_q[1:0] == 2'b01) && boff[0]) ||
                                (f3_q[1] && (boff != 2'b00)));
`else
  assign misalign = 1'b0;
`endif

  assign mem_we = (state_q == ACCESS) && we_q && !misalign && !rst;

  always_comb begin
    state_d  = state_q;
    gnt_d_d  = gnt_d_q;
    last_d_d = last_d_q;
    we_d     = we_q;
    f3_d     = f3_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    rdata_d  = rdata_q;
    err_d    = err_q;
    case (state_q)
      IDLE: begin
        if (acc_d) begin
          state_d  = ACCESS;
          gnt_d_d  = 1'b1;
          last_d_d = 1'b1;
          we_d     = d_we;
          f3_d     = d_func3;
          addr_d   = d_addr[AW+1:0];
          wdata_d  = d_wdata;
        end else if (acc_if) begin
          state_d  = ACCESS;
          gnt_d_d  = 1'b0;
          last_d_d = 1'b0;
          we_d     = 1'b0;
          f3_d     = 3'b010;
          addr_d   = {if_addr[AW+1:2], 2'b00};
          wdata_d  = '0;
        end
      end
      ACCESS: begin
        state_d = RESP;
        err_d   = misalign;
        rdata_d = (we_q || misalign) ? 32'd0 : ld_val;
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      gnt_d_q  <= 1'b0;
      last_d_q <= 1'b0;
      we_q     <= 1'b0;
      f3_q     <= 3'd0;
      addr_q   <= '0;
      wdata_q  <= '0;
      rdata_q  <= '0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      gnt_d_q  <= gnt_d_d;
      last_d_q <= last_d_d;
      we_q     <= we_d;
      f3_q     <= f3_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      rdata_q  <= rdata_d;
      err_q    <= err_d;
    end
  end

  // Array is never reset; only addressed byte lanes are written.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      for (int b = 0; b < 4; b++) begin
        if (be[b]) mem[idx][8*b +: 8] <= wlane[8*b +: 8];
      end
    end
  end

  assign resp      = (state_q == RESP);
  assign d_rvalid  = resp && gnt_d_q;
  assign if_rvalid = resp && !gnt_d_q;
  assign d_rdata   = d_rvalid ? rdata_q : 32'd0;
  assign if_rdata  = if_rvalid ? rdata_q : 32'd0;

`ifdef MEM_MISALIGN_ERR_EN
  assign d_err = d_rvalid && err_q;
  logic unused_addr;
  assign unused_addr = ^{if_addr[31:AW+2], if_addr[1:0], d_addr[31:AW+2]};
`else
  assign d_err = 1'b0;
  logic unused_addr;
  assign unused_addr = ^{if_addr[31:AW+2], if_addr[1:0], d_addr[31:AW+2], err_q};
`endif

endmodule

// File: tb/tb_mem_responder.sv
// Self-checking bench for mem_responder: directed scenarios plus randomized traffic vs a byte-array model.
module tb_mem_responder;
  localparam int DEPTH = 1024;

  logic        clk, rst;
  logic        if_req, if_ready, if_rvalid;
  logic [31:0] if_addr, if_rdata;
  logic        d_req, d_we, d_ready, d_rvalid, d_err;
  logic [31:0] d_addr, d_wdata, d_rdata;
  logic [2:0]  d_func3;

  int n_cmp = 0;
  int n_bad = 0;

  logic [7:0] mm [0:4*DEPTH-1];

  mem_responder #(.DEPTH_WORDS(DEPTH)) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_ready(if_ready), .if_rvalid(if_rvalid), .if_rdata(if_rdata),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_func3(d_func3), .d_wdata(d_wdata),
    .d_ready(d_ready), .d_rvalid(d_rvalid), .d_rdata(d_rdata), .d_err(d_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  function automatic int sz(input logic [2:0] f3);
    if (f3[1:0] == 2'b00) return 1;
    if (f3[1:0] == 2'b01) return 2;
    return 4;
  endfunction

  function automatic bit mis(input logic [2:0] f3, input logic [31:0] a);
`ifdef MEM_MISALIGN_ERR_EN
    return (a % sz(f3)) != 0;
`else
    return 1'b0;
`endif
  endfunction

  function automatic int base_of(input logic [2:0] f3, input logic [31:0] a);
    return int'((a & ~(sz(f3) - 1)) % (4 * DEPTH));
  endfunction

  function automatic logic [31:0] m_load(input logic [2:0] f3, input logic [31:0] a);
    logic [31:0] v;
    int b, n;
    v = 0; b = base_of(f3, a); n = sz(f3);
    for (int i = 0; i < n; i++) v = v | (32'(mm[b + i]) << (8 * i));
    if (!f3[2] && n == 1 && v[7])  v = v | 32'hFFFF_FF00;
    if (!f3[2] && n == 2 && v[15]) v = v | 32'hFFFF_0000;
    return v;
  endfunction

  task automatic m_store(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] wd);
    int b;
    b = base_of(f3, a);
    for (int i = 0; i < sz(f3); i++) mm[b + i] = 8'(wd >> (8 * i));
  endtask

  // ---------------- driver ----------------
  // Issues one transaction starting at a negedge; lat counts cycles from accept to rvalid (-1 = timeout).
  // xp counts stray rvalids: on the wrong port or longer than one cycle.
  task automatic txn(input bit pd, input logic we, input logic [2:0] f3, input logic [31:0] a,
                     input logic [31:0] wd, output logic [31:0] rd, output logic er,
                     output int lat, output int xp);
    int n;
    rd = '0; er = 1'b0; lat = -1; xp = 0; n = 0;
    if (pd) begin d_req = 1; d_we = we; d_func3 = f3; d_addr = a; d_wdata = wd; end
    else begin if_req = 1; if_addr = a; end
    #1;
    while (!(pd ? d_ready : if_ready) && n < 20) begin @(negedge clk); #1; n++; end
    if (!(pd ? d_ready : if_ready)) begin d_req = 0; if_req = 0; return; end
    @(negedge clk);
    d_req = 0; if_req = 0;
    d_addr = $urandom; d_wdata = $urandom; d_we = 1'($urandom); d_func3 = 3'($urandom); if_addr = $urandom;
    lat = 1;
    while (!(pd ? d_rvalid : if_rvalid) && lat < 8) begin
      if (pd ? if_rvalid : d_rvalid) xp++;
      @(negedge clk); lat++;
    end
    if (!(pd ? d_rvalid : if_rvalid)) begin lat = -1; return; end
    rd = pd ? d_rdata : if_rdata;
    er = d_err;
    if (pd ? if_rvalid : d_rvalid) xp++;
    @(negedge clk);
    if (d_rvalid || if_rvalid) xp++;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset;
    rst = 1; if_req = 1; d_req = 1; d_we = 0; d_func3 = 0; d_addr = 0; d_wdata = 0; if_addr = 0;
    repeat (3) @(negedge clk);
    n_cmp++; if (if_ready !== 1'b0) begin n_bad++; $display("FAIL reset_if_ready: got %b want 0", if_ready); end
    n_cmp++; if (d_ready !== 1'b0) begin n_bad++; $display("FAIL reset_d_ready: got %b want 0", d_ready); end
    n_cmp++; if ({if_rvalid, d_rvalid, d_err} !== 3'b000)
      begin n_bad++; $display("FAIL reset_strobes: got %b want 000", {if_rvalid, d_rvalid, d_err}); end
    n_cmp++; if ({if_rdata, d_rdata} !== 64'd0)
      begin n_bad++; $display("FAIL reset_rdata: got %h want 0", {if_rdata, d_rdata}); end
    if_req = 0; d_req = 0;
    rst = 0; #1;
    n_cmp++; if ({if_ready, d_ready} !== 2'b11)
      begin n_bad++; $display("FAIL idle_ready: got %b want 11", {if_ready, d_ready}); end
    @(negedge clk);
  endtask

  task automatic test_loads_after_sw;
    logic [31:0] rd; logic er; int lat, xp;
    txn(1, 1, 3'b010, 32'h10, 32'h8000_00F1, rd, er, lat, xp); m_store(3'b010, 32'h10, 32'h8000_00F1);
    n_cmp++; if (rd !== 32'd0 || lat != 2 || xp != 0)
      begin n_bad++; $display("FAIL sw_resp: got rd=%h lat=%0d xp=%0d want rd=0 lat=2 xp=0", rd, lat, xp); end
    txn(1, 0, 3'b000, 32'h10, 0, rd, er, lat, xp);
    n_cmp++; if (rd !== 32'hFFFF_FFF1 || lat != 2 || xp != 0)
      begin n_bad++; $display("FAIL lb: got rd=%h lat=%0d xp=%0d want rd=fffffff1 lat=2", rd, lat, xp); end
    txn(1, 0, 3'b100, 32'h10, 0, rd, er, lat, xp);
    n_cmp++; if (rd !== 32'h0000_00F1 || lat != 2)
      begin n_bad++; $display("FAIL lbu: got rd=%h lat=%0d want rd=000000f1 lat=2", rd, lat); end
    txn(1, 0, 3'b101, 32'h12, 0, rd, er, lat, xp);
    n_cmp++; if (rd !== 32'h0000_8000 || lat != 2)
      begin n_bad++; $display("FAIL lhu: got rd=%h lat=%0d want rd=00008000 lat=2", rd, lat); end
    txn(1, 0, 3'b001, 32'h12, 0, rd, er, lat, xp);
    n_cmp++; if (rd !== 32'hFFFF_8000)
      begin n_bad++; $display("FAIL lh: got rd=%h want ffff8000", rd); end
  endtask

  task automatic test_sb_fetch;
    logic [31:0] rd; logic er; int lat, xp;
    txn(1, 1, 3'b010, 32'h10, 32'h1122_3344, rd, er, lat, xp); m_store(3'b010, 32'h10, 32'h1122_3344);
    txn(1, 1, 3'b000, 32'h13, 32'h0000_00AB, rd, er, lat, xp); m_store(3'b000, 32'h13, 32'hAB);
    txn(0, 0, 3'b010, 32'h10, 0, rd, er, lat, xp);
    n_cmp++; if (rd !== 32'hAB22_3344 || lat != 2 || xp != 0)
      begin n_bad++; $display("FAIL sb_fetch: got rd=%h lat=%0d xp=%0d want rd=ab223344 lat=2", rd, lat, xp); end
    txn(0, 0, 3'b010, 32'h13, 0, rd, er, lat, xp);
    n_cmp++; if (rd !== 32'hAB22_3344)
      begin n_bad++; $display("FAIL fetch_low_bits: got %h want ab223344", rd); end
  endtask

  task automatic test_wrap;
    logic [31:0] rd; logic er; int lat, xp;
    txn(1, 1, 3'b010, 32'h1000, 32'hDEAD_BEEF, rd, er, lat, xp); m_store(3'b010, 32'h1000, 32'hDEAD_BEEF);
    txn(0, 0, 3'b010, 32'h0, 0, rd, er, lat, xp);
    n_cmp++; if (rd !== 32'hDEAD_BEEF)
      begin n_bad++; $display("FAIL wrap: got %h want deadbeef", rd); end
  endtask

  task automatic test_back_to_back;
    int cyc, nd, ni, stray;
    bit ord[$];
    int gcyc[$];
    bit exp_ord[4];
    logic [31:0] exp_d, exp_i;
    exp_ord[0] = 1; exp_ord[1] = 0; exp_ord[2] = 1; exp_ord[3] = 0;
    exp_d = m_load(3'b010, 32'h10); exp_i = m_load(3'b010, 32'h0);
    cyc = 0; nd = 0; ni = 0; stray = 0;
    d_req = 1; d_we = 0; d_func3 = 3'b010; d_addr = 32'h10; if_req = 1; if_addr = 32'h0;
    #1;
    while (ord.size() < 4 && cyc < 40) begin
      if (d_ready && if_ready) stray++;
      if (d_ready) begin ord.push_back(1); gcyc.push_back(cyc); end
      else if (if_ready) begin ord.push_back(0); gcyc.push_back(cyc); end
      if (d_rvalid) begin nd++; if (d_rdata !== exp_d) stray++; end
      if (if_rvalid) begin ni++; if (if_rdata !== exp_i) stray++; end
      @(negedge clk); cyc++;
    end
    d_req = 0; if_req = 0;
    repeat (4) begin
      if (d_rvalid) begin nd++; if (d_rdata !== exp_d) stray++; end
      if (if_rvalid) begin ni++; if (if_rdata !== exp_i) stray++; end
      @(negedge clk);
    end
    n_cmp++; if (ord.size() != 4)
      begin n_bad++; $display("FAIL b2b_grants: got %0d want 4", ord.size()); end
    for (int i = 0; i < 4 && i < ord.size(); i++) begin
      n_cmp++; if (ord[i] !== exp_ord[i])
        begin n_bad++; $display("FAIL b2b_order[%0d]: got %0d want %0d", i, ord[i], exp_ord[i]); end
    end
    for (int i = 1; i < gcyc.size(); i++) begin
      n_cmp++; if (gcyc[i] - gcyc[i-1] != 3)
        begin n_bad++; $display("FAIL b2b_spacing[%0d]: got %0d want 3", i, gcyc[i] - gcyc[i-1]); end
    end
    n_cmp++; if (nd != 2 || ni != 2 || stray != 0)
      begin n_bad++; $display("FAIL b2b_rvalid: got d=%0d i=%0d bad=%0d want 2 2 0", nd, ni, stray); end
  endtask

  task automatic test_misalign;
    logic [31:0] rd; logic er; int lat, xp;
    logic [31:0] exp_rd; logic exp_er;
    txn(1, 1, 3'b010, 32'h20, 32'hCAFE_F00D, rd, er, lat, xp); m_store(3'b010, 32'h20, 32'hCAFE_F00D);
    txn(1, 0, 3'b010, 32'h22, 0, rd, er, lat, xp);
`ifdef MEM_MISALIGN_ERR_EN
    exp_rd = 32'd0; exp_er = 1'b1;
`else
    exp_rd = 32'hCAFE_F00D; exp_er = 1'b0;
`endif
    n_cmp++; if (rd !== exp_rd || er !== exp_er || lat != 2)
      begin n_bad++; $display("FAIL lw_misalign: got rd=%h err=%b lat=%0d want rd=%h err=%b", rd, er, lat, exp_rd, exp_er); end
    txn(1, 1, 3'b001, 32'h21, 32'h0000_1234, rd, er, lat, xp);
    n_cmp++; if (er !== exp_er || rd !== 32'd0)
      begin n_bad++; $display("FAIL sh_misalign: got rd=%h err=%b want rd=0 err=%b", rd, er, exp_er); end
    if (!mis(3'b001, 32'h21)) m_store(3'b001, 32'h21, 32'h1234);
    txn(1, 0, 3'b010, 32'h20, 0, rd, er, lat, xp);
`ifdef MEM_MISALIGN_ERR_EN
    exp_rd = 32'hCAFE_F00D;
`else
    exp_rd = 32'hCAFE_1234;
`endif
    n_cmp++; if (rd !== exp_rd || er !== 1'b0)
      begin n_bad++; $display("FAIL sh_misalign_effect: got rd=%h err=%b want %h err=0", rd, er, exp_rd); end
  endtask

  task automatic test_reset_abort;
    logic [31:0] rd; logic er; int lat, xp, seen;
    txn(1, 1, 3'b010, 32'h40, 32'h0BAD_F00D, rd, er, lat, xp); m_store(3'b010, 32'h40, 32'h0BAD_F00D);
    d_req = 1; d_we = 1; d_func3 = 3'b010; d_addr = 32'h40; d_wdata = 32'h1234_5678;
    #1;
    n_cmp++; if (d_ready !== 1'b1)
      begin n_bad++; $display("FAIL abort_accept: got ready=%b want 1", d_ready); end
    @(negedge clk);
    d_req = 0; rst = 1;
    seen = 0;
    @(negedge clk);
    rst = 0;
    repeat (4) begin #1; if (d_rvalid || if_rvalid) seen++; @(negedge clk); end
    n_cmp++; if (seen != 0)
      begin n_bad++; $display("FAIL abort_rvalid: got %0d pulses want 0", seen); end
    txn(1, 0, 3'b010, 32'h40, 0, rd, er, lat, xp);
    n_cmp++; if (rd !== 32'h0BAD_F00D)
      begin n_bad++; $display("FAIL abort_no_write: got %h want 0badf00d", rd); end
  endtask

  task automatic test_random;
    logic [31:0] rd, a, wd, exp_rd; logic er, exp_er, we; logic [2:0] f3; int lat, xp; bit pd;
    for (int w = 0; w < 16; w++) begin
      wd = $urandom;
      txn(1, 1, 3'b010, 32'h100 + 4*w, wd, rd, er, lat, xp); m_store(3'b010, 32'h100 + 4*w, wd);
    end
    for (int k = 0; k < 120; k++) begin
      pd = $urandom_range(0, 2) != 0;
      we = 1'($urandom); f3 = 3'($urandom); a = 32'h100 + $urandom_range(0, 63); wd = $urandom;
      if (!pd) begin
        exp_rd = m_load(3'b010, a & ~32'd3); exp_er = 1'b0;
        txn(0, 0, 3'b010, a, 0, rd, er, lat, xp);
      end else begin
        exp_er = mis(f3, a);
        exp_rd = (we || exp_er) ? 32'd0 : m_load(f3, a);
        txn(1, we, f3, a, wd, rd, er, lat, xp);
        if (we && !exp_er) m_store(f3, a, wd);
      end
      n_cmp++; if (rd !== exp_rd || (pd && er !== exp_er) || lat != 2 || xp != 0) begin
        n_bad++;
        $display("FAIL rand[%0d] port=%0d we=%b f3=%0d a=%h: got rd=%h err=%b lat=%0d xp=%0d want rd=%h err=%b lat=2",
                 k, pd, we, f3, a, rd, er, lat, xp, exp_rd, exp_er);
      end
    end
  endtask

  initial begin
    test_reset;
    test_loads_after_sw;
    test_sb_fetch;
    test_wrap;
    test_back_to_back;
    test_misalign;
    test_reset_abort;
    test_random;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
endmodule
